// File: rtl/approx_mac_seq.sv
// Purpose : sequential approximate MAC; shift-add product and accumulation use a lower-part-OR adder.
// Latency : W MUL cycles plus one ACC cycle per pair; out_valid follows the last pair's ACC cycle.
// Backpr. : in_ready is low until the pair is accumulated; a pending result holds until out_ready.
module approx_mac_seq #(
    parameter int W     = 8,
    parameter int K     = 4,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(W - 1);

    // Masks selecting the K approximate (OR-only) low bits of each adder.
    localparam logic [2*W-1:0] P_ONE = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] P_LO  = (P_ONE << K) - P_ONE;
    localparam logic [ACC_W-1:0] A_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] A_LO  = (A_ONE << K) - A_ONE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Product-width approximate add. Masking the low bits out of the exact
    // part means no carry enters bit K; the carry out of the top bit drops.
    function automatic logic [2*W-1:0] add_p(input logic [2*W-1:0] x,
                                             input logic [2*W-1:0] y);
        add_p = ((x & ~P_LO) + (y & ~P_LO)) | ((x | y) & P_LO);
    endfunction

    // Accumulator-width approximate add; bit ACC_W carries the carry-out.
    function automatic logic [ACC_W:0] add_acc(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y);
        logic [ACC_W:0] xe;
        logic [ACC_W:0] ye;
        xe = {1'b0, x & ~A_LO};
        ye = {1'b0, y & ~A_LO};
        add_acc = (xe + ye) | {1'b0, (x | y) & A_LO};
    endfunction

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             last_q, last_d;
    logic [2*W-1:0]   p_q, p_d;
    logic [IW-1:0]    i_q, i_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic [2*W-1:0]   a_shift;
    logic [ACC_W:0]   acc_sum;

    assign a_shift = {{W{1'b0}}, a_q} << i_q;
    assign acc_sum = add_acc(acc_q, ACC_W'(p_q));

    assign acc_out = acc_q;
    assign ovf     = ovf_q;

    // State and datapath registers; reset discards any partial dot product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            p_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            p_q     <= p_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        last_d    = last_q;
        p_d       = p_q;
        i_d       = i_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    last_d  = last;
                    p_d     = '0;
                    i_d     = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // One multiplier bit per cycle, LSB first.
                if (b_q[i_q]) begin
                    p_d = add_p(p_q, a_shift);
                end
                if (i_q == I_LAST) begin
                    state_d = ACC;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ACC: begin
                // Saturation is sticky for the rest of the dot product.
                if (acc_sum[ACC_W] || ovf_q) begin
                    acc_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = acc_sum[ACC_W-1:0];
                end
                state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
